uart_tx_arbiter: RTL and testbench

Shares the single uart register-bus transmitter among N_REQ requesters, each submitting a 16-bit word over valid/ready. A round-robin grant selects one requester. The block then sequences the uart bus for each of the two bytes: poll the status register until TX ready, then write the byte to the data register. This replaces per-source hand-built UART sequencers.

---
 rtl/uart_tx_arbiter_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 93 +++++++++
 tb/tb_uart_tx_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: uart register map defaults, FSM state encoding and byte-order helper
package uart_tx_arbiter_pkg;
  localparam logic [7:0] STATUS_ADDR_DEF  = 8'd1;
  localparam logic [7:0] DATA_ADDR_DEF    = 8'd2;
  localparam int         TX_READY_BIT_DEF = 1;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POLL_A  = 3'd1,
    CHECK_A = 3'd2,
    WRITE_A = 3'd3,
    POLL_B  = 3'd4,
    CHECK_B = 3'd5,
    WRITE_B = 3'd6
  } state_e;
  function automatic logic [7:0] pick_byte(input logic [15:0] w, input logic msb_first, input logic second);
    return (msb_first ^ second) ? w[15:8] : w[7:0];
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round robin; req/ptr in, one-hot gnt and its index idx out, search starts at ptr+1
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [N-1:0] gnt,
  output logic [2:0]   idx
);
  logic found;
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (!found && req[j] && j == (int'(ptr) + 1 + i) % N) begin
          found = 1'b1;
          gnt[j] = 1'b1;
          idx = 3'(j);
        end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: RR-shares one uart bus among N_REQ 16-bit valid/ready sources; ports req_*, busy/grant_id/words_sent status, uart_* register bus
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int         N_REQ        = 4,
  parameter bit         MSB_FIRST    = 1'b1,
  parameter logic [7:0] STATUS_ADDR  = STATUS_ADDR_DEF,
  parameter logic [7:0] DATA_ADDR    = DATA_ADDR_DEF,
  parameter int         TX_READY_BIT = TX_READY_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [16*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic [15:0]          words_sent,
  output logic [7:0]           uart_address,
  output logic [7:0]           uart_din,
  output logic                 uart_w_en,
  output logic                 uart_r_en,
  input  logic [7:0]           uart_dout
);
  state_e state_q, state_d;
  logic [2:0] ptr_q, ptr_d, grant_id_q, grant_id_d, gnt_idx;
  logic [15:0] word_q, word_d, words_sent_q, words_sent_d, word_sel;
  logic [7:0] addr_q, addr_d, din_q, din_d;
  logic w_en_q, w_en_d, r_en_q, r_en_d;
  logic [N_REQ-1:0] gnt;
  logic accept, tx_ready, unused_dout;
  rr_arbiter #(.N(N_REQ)) u_rr (.req(req_valid), .ptr(ptr_q), .gnt(gnt), .idx(gnt_idx));
  // ready is masked during reset so every output reads 0 while rst is held
  assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;
  assign accept = |req_ready;
  assign tx_ready = uart_dout[TX_READY_BIT];
  assign unused_dout = ^uart_dout;
  always_comb begin
    word_sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[i]) word_sel = req_data[16*i +: 16];
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? POLL_A : IDLE;
      POLL_A:  state_d = CHECK_A;
      CHECK_A: state_d = tx_ready ? WRITE_A : POLL_A;
      WRITE_A: state_d = POLL_B;
      POLL_B:  state_d = CHECK_B;
      CHECK_B: state_d = tx_ready ? WRITE_B : POLL_B;
      default: state_d = IDLE;
    endcase
    ptr_d = accept ? gnt_idx : ptr_q;
    grant_id_d = accept ? gnt_idx : grant_id_q;
    word_d = accept ? word_sel : word_q;
    words_sent_d = (state_q == WRITE_B) ? words_sent_q + 16'd1 : words_sent_q;
    // bus strobes are decoded from the next state so they register in step with it
    r_en_d = state_d inside {POLL_A, CHECK_A, POLL_B, CHECK_B};
    w_en_d = state_d inside {WRITE_A, WRITE_B};
    addr_d = r_en_d ? STATUS_ADDR : w_en_d ? DATA_ADDR : addr_q;
    din_d = w_en_d ? pick_byte(word_q, MSB_FIRST, state_d == WRITE_B) : din_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= 3'(N_REQ - 1);
      grant_id_q <= '0;
      word_q <= '0;
      words_sent_q <= '0;
      addr_q <= '0;
      din_q <= '0;
      w_en_q <= 1'b0;
      r_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_id_q <= grant_id_d;
      word_q <= word_d;
      words_sent_q <= words_sent_d;
      addr_q <= addr_d;
      din_q <= din_d;
      w_en_q <= w_en_d;
      r_en_q <= r_en_d;
    end
  assign busy = state_q != IDLE;
  assign grant_id = grant_id_q;
  assign words_sent = words_sent_q;
  assign uart_address = addr_q;
  assign uart_din = din_q;
  assign uart_w_en = w_en_q;
  assign uart_r_en = r_en_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed plus random stimulus against a transaction-level model, MSB- and LSB-first instances side by side
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam logic [7:0] SA = 8'd1;
  localparam logic [7:0] DA = 8'd2;
  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, req_ready2;
  logic [16*N-1:0] req_data = '0;
  logic busy, busy2, w_en, w_en2, r_en, r_en2;
  logic [2:0] grant_id, grant_id2;
  logic [15:0] words_sent, words_sent2;
  logic [7:0] addr, addr2, din, din2, uart_dout = '0;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int m_op = 0, m_byte = 0, m_ptr = N - 1, m_gid = 0, mw;
  logic [15:0] m_word = '0, m_cnt = '0, m_cnt2 = '0;
  logic [7:0] m_addr = '0, m_din = '0, m_din2 = '0;
  logic [7:0] wlog[$], w2log[$];
  int wcyc[$], alog[$];
  int n_acc = 0, n_busy = 0, n_rd = 0, n_rdy_cyc = 0;
  int preload_n = 0, preload_seen = 0, n_denied = 0, deny_target = 0;
  logic rdy_mode = 1'b0, rdy_b;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .busy(busy), .grant_id(grant_id), .words_sent(words_sent), .uart_address(addr),
    .uart_din(din), .uart_w_en(w_en), .uart_r_en(r_en), .uart_dout(uart_dout));
  uart_tx_arbiter #(.N_REQ(N), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready2),
    .busy(busy2), .grant_id(grant_id2), .words_sent(words_sent2), .uart_address(addr2),
    .uart_din(din2), .uart_w_en(w_en2), .uart_r_en(r_en2), .uart_dout(uart_dout));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int winner(logic [N-1:0] v, int p);
    for (int i = 1; i <= N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // emulated uart status: TX ready either always, randomly, or denied for a scripted number of checks
  always @(negedge clk) begin
    rdy_b = rdy_mode ? ($urandom % 3 != 0) : 1'b1;
    if (m_op == 2 && n_denied < deny_target) begin
      rdy_b = 1'b0;
      n_denied++;
    end
    uart_dout = 8'($urandom);
    uart_dout[1] = rdy_b;
  end

  // model: one word = accept, then per byte (status read pair)+ until ready, then one data write
  always @(negedge clk) begin
    #4;
    cyc++;
    if (preload_n != preload_seen) begin
      m_cnt = 16'hFFFF;
      preload_seen = preload_n;
    end
    if (rst) begin
      m_op = 0; m_byte = 0; m_ptr = N - 1; m_gid = 0; m_cnt = 0; m_cnt2 = 0;
      m_addr = 0; m_din = 0; m_din2 = 0; m_word = 0;
    end
    mw = winner(req_valid, m_ptr);
    chk("req_ready", req_ready, (m_op == 0 && !rst && mw >= 0) ? (1 << mw) : 0);
    chk("busy", busy, m_op != 0);
    chk("grant_id", grant_id, m_gid);
    chk("words_sent", words_sent, m_cnt);
    chk("r_en", r_en, m_op == 1 || m_op == 2);
    chk("w_en", w_en, m_op == 3);
    chk("address", addr, m_addr);
    chk("din", din, m_din);
    chk("lsb_req_ready", req_ready2, (m_op == 0 && !rst && mw >= 0) ? (1 << mw) : 0);
    chk("lsb_busy", busy2, m_op != 0);
    chk("lsb_grant_id", grant_id2, m_gid);
    chk("lsb_words_sent", words_sent2, m_cnt2);
    chk("lsb_r_en", r_en2, m_op == 1 || m_op == 2);
    chk("lsb_w_en", w_en2, m_op == 3);
    chk("lsb_address", addr2, m_addr);
    chk("lsb_din", din2, m_din2);
    if (w_en) begin wlog.push_back(din); wcyc.push_back(cyc); end
    if (w_en2) w2log.push_back(din2);
    if (busy) n_busy++;
    if (r_en) n_rd++;
    if (|req_ready) n_rdy_cyc++;
    if (|(req_ready & req_valid) && !rst) begin
      n_acc++;
      for (int j = 0; j < N; j++) if (req_ready[j]) alog.push_back(j);
    end
    if (!rst)
      case (m_op)
        0: if (mw >= 0) begin
             m_word = req_data[16*mw +: 16]; m_gid = mw; m_ptr = mw; m_op = 1; m_byte = 0; m_addr = SA;
           end
        1: m_op = 2;
        2: if (uart_dout[1]) begin
             m_op = 3; m_addr = DA;
             m_din = (m_byte == 0) ? m_word[15:8] : m_word[7:0];
             m_din2 = (m_byte == 0) ? m_word[7:0] : m_word[15:8];
           end else m_op = 1;
        default: if (m_byte == 0) begin
             m_byte = 1; m_op = 1; m_addr = SA;
           end else begin
             m_op = 0; m_cnt++; m_cnt2++;
           end
      endcase
  end

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 500) begin @(negedge clk); k++; end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic send(int idx, logic [15:0] d);
    int a0, k;
    a0 = n_acc;
    @(negedge clk);
    req_data[16*idx +: 16] = d;
    req_valid[idx] = 1'b1;
    k = 0;
    while (n_acc == a0 && k < 200) begin @(negedge clk); k++; end
    chk("accept_timeout", n_acc != a0, 1);
    req_valid[idx] = 1'b0;
    wait_idle();
  endtask

  initial begin
    int b0, r0, a0, acc0, k;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_words", words_sent, 0);
    chk("rst_w_en", w_en, 0);
    chk("rst_r_en", r_en, 0);
    chk("rst_addr", addr, 0);
    rst = 1'b0;
    b0 = n_busy; r0 = n_rdy_cyc;
    send(2, 16'hA55A);
    chk("t2_ready_pulses", n_rdy_cyc - r0, 1);
    chk("t2_busy_cycles", n_busy - b0, 6);
    chk("t2_nwrites", wlog.size(), 2);
    chk("t2_byte_a", wlog[0], 8'hA5);
    chk("t2_byte_b", wlog[1], 8'h5A);
    chk("t2_spacing", wcyc[1] - wcyc[0], 3);
    chk("t2_words", words_sent, 1);
    chk("t2_grant", grant_id, 2);
    deny_target = n_denied + 5; r0 = n_rd; a0 = wlog.size();
    send(0, 16'h1234);
    chk("t4_denied", n_denied, deny_target);
    chk("t4_reads", n_rd - r0, 14);
    chk("t4_nwrites", wlog.size() - a0, 2);
    chk("t4_byte_a", wlog[a0], 8'h12);
    chk("t4_byte_b", wlog[a0+1], 8'h34);
    @(negedge clk);
    req_data[16 +: 16] = 16'hCAFE;
    req_valid = 4'b0010;
    k = 0;
    while (!w_en && k < 100) begin @(negedge clk); k++; end
    chk("t1_reach_write", w_en, 1);
    rst = 1'b1;
    req_valid = '0;
    #1;
    chk("t1_busy", busy, 0);
    chk("t1_w_en", w_en, 0);
    chk("t1_r_en", r_en, 0);
    chk("t1_addr", addr, 0);
    chk("t1_din", din, 0);
    chk("t1_grant", grant_id, 0);
    chk("t1_words", words_sent, 0);
    chk("t1_ready", req_ready, 0);
    @(negedge clk);
    a0 = wlog.size(); b0 = w2log.size(); acc0 = alog.size();
    for (int i = 0; i < N; i++) req_data[16*i +: 16] = 16'h1000 + 16'(i);
    req_valid = 4'hF;
    rst = 1'b0;
    k = 0;
    while (alog.size() < acc0 + 5 && k < 200) begin @(negedge clk); k++; end
    req_valid = '0;
    wait_idle();
    chk("t3_naccepts", alog.size() - acc0, 5);
    chk("t3_nwrites", wlog.size() - a0, 10);
    for (int i = 0; i < 5; i++) begin
      chk("t3_grant_order", alog[acc0+i], i % N);
      chk("t3_msb_hi", wlog[a0+2*i], 8'h10);
      chk("t3_msb_lo", wlog[a0+2*i+1], 8'(i % N));
      chk("t3_lsb_lo", w2log[b0+2*i], 8'(i % N));
      chk("t3_lsb_hi", w2log[b0+2*i+1], 8'h10);
    end
    chk("t3_words", words_sent, 5);
    a0 = wlog.size(); b0 = w2log.size();
    send(0, 16'hBEEF);
    chk("t5_msb_a", wlog[a0], 8'hBE);
    chk("t5_msb_b", wlog[a0+1], 8'hEF);
    chk("t5_lsb_a", w2log[b0], 8'hEF);
    chk("t5_lsb_b", w2log[b0+1], 8'hBE);
    @(negedge clk);
    force u_msb.words_sent_q = 16'hFFFF;
    preload_n++;
    @(negedge clk);
    release u_msb.words_sent_q;
    send(3, 16'h0F0F);
    chk("t6_wrap", words_sent, 0);
    chk("t6_grant", grant_id, 3);
    rdy_mode = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      req_valid = 4'($urandom);
      for (int i = 0; i < N; i++)
        if ($urandom % 4 == 0) req_data[16*i +: 16] = 16'($urandom);
    end
    req_valid = '0;
    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
